// File: rtl/mpd_pkg.sv
// mpd_pkg
// Shared definitions for the multi-project fabric return-bus selector:
// the sequencing state encoding and the width of the reset-hold counter.
package mpd_pkg;

  // Width of the down-counter that times the per-project reset hold.
  localparam int MPD_RST_CNT_W = 8;

  // OFF   : fabric not configured, every project held off
  // GATE  : one-cycle gap with every clock stopped while the selection switches
  // RESET : selected project clocked but held in reset
  // RUN   : selected project live and driving the fabric return bus
  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_GATE  = 2'd1,
    ST_RESET = 2'd2,
    ST_RUN   = 2'd3
  } mpd_state_e;

endpackage

// File: rtl/mpd_uprj_sel.sv
// mpd_uprj_sel
// Chooses one of NPRJ user projects to own the fabric return bus. A newly
// selected project first sees a clock-stopped gap, then RST_CYCLES clocked
// cycles in reset, then runs; its output word is registered onto fab_in.
//
// Ports
//   fabric_clk   in   clock
//   resetb       in   asynchronous active-low reset
//   fabric_done  in   fabric configured; low forces every project off
//   sel_stb      in   one-cycle select request
//   sel_req      in   requested project index (sampled with sel_stb)
//   uprj_out     in   concatenated project outputs, project i at [i*W +: W]
//   fab_in       out  registered word of the running project (0 otherwise)
//   prj_rstn     out  per-project active-low reset (registered)
//   prj_clk_en   out  per-project clock enable (registered)
//   cur_sel      out  active project index
//   busy         out  high whenever the sequencer is not in RUN
//   sel_err      out  one-cycle pulse for an out-of-range request in RUN
module mpd_uprj_sel
  import mpd_pkg::*;
#(
  parameter int NPRJ       = 4,
  parameter int W          = 128,
  parameter int RST_CYCLES = 16,
  localparam int SEL_W     = (NPRJ > 2) ? $clog2(NPRJ) : 1
) (
  input  logic              fabric_clk,
  input  logic              resetb,
  input  logic              fabric_done,
  input  logic              sel_stb,
  input  logic [SEL_W-1:0]  sel_req,
  input  logic [NPRJ*W-1:0] uprj_out,
  output logic [W-1:0]      fab_in,
  output logic [NPRJ-1:0]   prj_rstn,
  output logic [NPRJ-1:0]   prj_clk_en,
  output logic [SEL_W-1:0]  cur_sel,
  output logic              busy,
  output logic              sel_err
);

  localparam logic [SEL_W:0]               NPRJ_L   = (SEL_W+1)'(NPRJ);
  localparam logic [MPD_RST_CNT_W-1:0]     RST_LOAD = MPD_RST_CNT_W'(RST_CYCLES);

  mpd_state_e                r_state;
  mpd_state_e                w_next_state;
  logic [SEL_W-1:0]          r_pending;
  logic [SEL_W-1:0]          w_next_sel;
  logic [MPD_RST_CNT_W-1:0]  r_cnt;
  logic                      w_req_ok;
  logic                      w_take_sel;
  logic                      w_bad_sel;
  logic [NPRJ-1:0]           w_rstn_d;
  logic [NPRJ-1:0]           w_clk_en_d;

  // Requests are only honoured in RUN; a falling fabric_done overrides them.
  // The extra zero bit lets the range check work when NPRJ fills SEL_W.
  assign w_req_ok   = ({1'b0, sel_req} < NPRJ_L);
  assign w_take_sel = (r_state == ST_RUN) && fabric_done && sel_stb && w_req_ok;
  assign w_bad_sel  = (r_state == ST_RUN) && fabric_done && sel_stb && !w_req_ok;
  assign busy       = (r_state != ST_RUN);

  // State register.
  always_ff @(posedge fabric_clk or negedge resetb) begin
    if (!resetb) begin
      r_state <= ST_OFF;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state, plus the project index that will be active after the edge.
  // The index only switches when leaving GATE, and returns to 0 in OFF.
  always_comb begin
    w_next_state = r_state;
    w_next_sel   = cur_sel;
    if (!fabric_done) begin
      w_next_state = ST_OFF;
    end else begin
      case (r_state)
        ST_OFF:   w_next_state = ST_GATE;
        ST_GATE:  w_next_state = ST_RESET;
        ST_RESET: if (r_cnt <= 8'd1) w_next_state = ST_RUN;
        ST_RUN:   if (w_take_sel) w_next_state = ST_GATE;
        default:  w_next_state = ST_OFF;
      endcase
    end
    if (w_next_state == ST_OFF) begin
      w_next_sel = '0;
    end else if (r_state == ST_GATE) begin
      w_next_sel = r_pending;
    end
  end

  // Project controls are decoded from the next state so the registered
  // vectors move on the same edge as the state itself.
  always_comb begin
    w_rstn_d   = '0;
    w_clk_en_d = '0;
    case (w_next_state)
      ST_RESET: begin
        w_clk_en_d[w_next_sel] = 1'b1;
      end
      ST_RUN: begin
        w_clk_en_d[w_next_sel] = 1'b1;
        w_rstn_d[w_next_sel]   = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Datapath registers. The counter is loaded on GATE exit and then counts
  // down once per RESET cycle, saturating at zero.
  always_ff @(posedge fabric_clk or negedge resetb) begin
    if (!resetb) begin
      cur_sel    <= '0;
      r_pending  <= '0;
      r_cnt      <= '0;
      fab_in     <= '0;
      prj_rstn   <= '0;
      prj_clk_en <= '0;
      sel_err    <= 1'b0;
    end else begin
      cur_sel    <= w_next_sel;
      prj_rstn   <= w_rstn_d;
      prj_clk_en <= w_clk_en_d;
      sel_err    <= w_bad_sel;

      if (w_next_state == ST_OFF) begin
        r_pending <= '0;
      end else if (w_take_sel) begin
        r_pending <= sel_req;
      end

      if (w_next_state == ST_OFF) begin
        r_cnt <= '0;
      end else if (r_state == ST_GATE) begin
        r_cnt <= RST_LOAD;
      end else if ((r_state == ST_RESET) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end

      if ((r_state == ST_RUN) && fabric_done) begin
        fab_in <= uprj_out[cur_sel*W +: W];
      end else begin
        fab_in <= '0;
      end
    end
  end

endmodule

// File: doc/mpd_uprj_sel.md
MPD_UPRJ_SEL -- requirements
Module: mpd_uprj_sel

Interface
REQ-001 Parameter NPRJ, default 4: number of user projects sharing the fabric return bus; legal range 2..16.
REQ-002 Parameter W, default 128: per-project return-bus width in bits.
REQ-003 Parameter RST_CYCLES, default 16: cycles a newly selected project is held in reset with its clock enabled; legal range 1..255.
REQ-004 Derived SEL_W = max(1, clog2(NPRJ)).
REQ-005 fabric_clk  in  1  clock; the reset is resetb, asynchronous, active-low, and the clock is fabric_clk.
REQ-006 resetb  in  1  asynchronous active-low reset.
REQ-007 fabric_done  in  1  fabric configured; low forces all projects off.
REQ-008 sel_stb  in  1  one-cycle select request from fabric.
REQ-009 sel_req  in  SEL_W  requested project index, sampled when sel_stb=1.
REQ-010 uprj_out  in  NPRJ*W  concatenated project outputs; project i at [i*W +: W].
REQ-011 fab_in  out  W  registered selected-project data to fabric.
REQ-012 prj_rstn  out  NPRJ  per-project active-low reset, registered.
REQ-013 prj_clk_en  out  NPRJ  per-project clock enable, registered.
REQ-014 cur_sel  out  SEL_W  active project index.
REQ-015 busy  out  1  high when state is not RUN.
REQ-016 sel_err  out  1  one-cycle pulse on an out-of-range request.

Function
REQ-017 The FSM SHALL have states OFF, GATE, RESET and RUN.
REQ-018 OFF: all prj_rstn=0, all prj_clk_en=0; on fabric_done=1 go to GATE with pending index 0.
REQ-019 GATE lasts 1 cycle: all prj_clk_en=0, all prj_rstn=0, cur_sel<=pending; then go to RESET with the counter loaded to RST_CYCLES.
REQ-020 RESET lasts exactly RST_CYCLES cycles: prj_clk_en[cur_sel]=1, prj_rstn all 0; then go to RUN.
REQ-021 RUN: prj_rstn[cur_sel]=1 and prj_clk_en[cur_sel]=1; non-selected bits are always 0 in both vectors.
REQ-022 prj_rstn and prj_clk_en SHALL be registered and decoded from the next state, so they change on the same edge as the state.
REQ-023 fab_in <= uprj_out[cur_sel*W +: W] when state==RUN, else 0, giving 1-cycle latency; the first valid word appears one cycle after RUN entry.
REQ-024 In RUN, sel_stb=1 with sel_req<NPRJ SHALL latch pending=sel_req and go to GATE; an equal index restarts the current project.
REQ-025 In RUN, sel_stb=1 with sel_req>=NPRJ SHALL pulse sel_err for 1 cycle and cause no state change.
REQ-026 sel_stb while busy=1 SHALL be ignored, with no sel_err and no queuing.
REQ-027 fabric_done=0 in any state SHALL move to OFF at the next edge and clear fab_in at the same edge.
REQ-028 If fabric_done falls in the same cycle as sel_stb, the transition to OFF wins.
REQ-029 The RESET counter is SEL_W-independent, 8 bits wide, counts down and does not wrap.

Reset
REQ-030 resetb=0 SHALL asynchronously force: state OFF, cur_sel=0, pending=0, counter=0, fab_in=0, prj_rstn=0, prj_clk_en=0, sel_err=0; busy=1.
REQ-031 Reset asserted mid-RESET or mid-RUN SHALL take effect immediately; on release, the block restarts from OFF.

Structure
REQ-032 The state enum and the MPD_RST_CNT_W=8 constant SHALL live in shared package mpd_pkg.
REQ-033 The block SHALL be a single module with no sub-modules; the output mux is an inline indexed part-select.

Verification (NPRJ=4, W=8, RST_CYCLES=4)
REQ-034 Release resetb with fabric_done=0 -> busy=1, fab_in=0x00, prj_rstn=0000, prj_clk_en=0000, cur_sel=0 for 20 cycles.
REQ-035 fabric_done rises, seen at edge k -> GATE@k; RESET@k+1..k+4 with clk_en=0001, rstn=0000; RUN@k+5 with rstn=0001; fab_in=uprj_out[7:0]=0xA5 from k+6.
REQ-036 In RUN, sel_stb with sel_req=2 -> 1 GATE cycle with clk_en=0000, then 4 RESET cycles with clk_en=0100; then RUN, cur_sel=2, fab_in=uprj_out[23:16].
REQ-037 sel_req=3 while busy -> ignored; with NPRJ=3, sel_req=3 in RUN -> sel_err=1 for exactly 1 cycle, cur_sel unchanged.
REQ-038 fabric_done dropped during RESET cycle 2 -> OFF at next edge, all outputs 0; re-raised -> full sequence restarts with index 0.
REQ-039 resetb pulsed low mid-RUN -> outputs 0 without waiting for a clock edge; sel_stb with sel_req=cur_sel in RUN -> 4-cycle reset of the same project.
